// File: rtl/uart_tx_fifo_if.sv
// Push-side bus of the FIFO-buffered UART transmitter: host writes and FIFO status.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 push;
  logic [DATA_BITS-1:0] push_data;
  logic                 flush;
  logic                 full;
  logic [LW-1:0]        level;
  logic                 overrun;

  modport master (output push, push_data, flush, input  full, level, overrun);
  modport slave  (input  push, push_data, flush, output full, level, overrun);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: configurable width, parity and stop bits, CTS-gated launch.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic [DIV_WIDTH-1:0] rate,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 cts,
  output logic                 tx,
  output logic                 busy,
  uart_tx_fifo_if.slave        bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;
  logic                 ovr;

  state_t               state, state_nx;
  logic [DIV_WIDTH-1:0] cnt, rate_q, rate_eff;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg, head;
  logic                 par_en_q, par_q, two_q, stop2;

  logic full_w, empty, tick, last_stop, launch, wr_en;

  assign full_w    = (count == LW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign tick      = (cnt == DIV_WIDTH'(1));
  assign last_stop = (state == STOP) && tick && (!two_q || stop2);
  assign launch    = ((state == IDLE) || last_stop) && !empty && cts;
  // full is the registered occupancy, so a same-cycle pop never frees a slot for this push
  assign wr_en     = bus.push && !full_w && !bus.flush;
  assign rate_eff  = (rate < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : rate;
  assign head      = mem[rd_ptr];

  assign bus.full    = full_w;
  assign bus.level   = count;
  assign bus.overrun = ovr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.push_data;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (launch) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, launch})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (bus.push && full_w) ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (launch) state_nx = START;
      START:  if (tick) state_nx = DATA;
      DATA:   if (tick && bit_idx == BW'(DATA_BITS - 1)) state_nx = par_en_q ? PARITY : STOP;
      PARITY: if (tick) state_nx = STOP;
      STOP:   if (last_stop) state_nx = launch ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame settings are captured at launch so mid-frame config changes wait for the next frame
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt      <= '0;
      rate_q   <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      two_q    <= 1'b0;
      stop2    <= 1'b0;
    end else if (launch) begin
      cnt      <= rate_eff;
      rate_q   <= rate_eff;
      bit_idx  <= '0;
      shreg    <= head;
      par_en_q <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_q    <= (^head) ^ (parity_mode == 2'b10);
      two_q    <= two_stop;
      stop2    <= 1'b0;
    end else if (state != IDLE) begin
      if (tick) begin
        cnt <= rate_q;
        if (state == DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_idx + BW'(1);
        end
        if (state == STOP) stop2 <= 1'b1;
      end else begin
        cnt <= cnt - DIV_WIDTH'(1);
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      PARITY:  tx = par_q;
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a frame-level waveform model, plus directed scenarios.
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        nReset;
  logic [15:0] rate;
  logic [1:0]  pm;
  logic        two, cts;
  logic        tx8, busy8, tx9, busy9;
  int          total = 0, bad = 0;
  bit          chk_on = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) bus8();
  uart_tx_fifo_if #(.DATA_BITS(9), .FIFO_DEPTH(8)) bus9();

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut8 (
    .clk(clk), .nReset(nReset), .rate(rate), .parity_mode(pm), .two_stop(two),
    .cts(cts), .tx(tx8), .busy(busy8), .bus(bus8));

  uart_tx_fifo #(.DATA_BITS(9), .FIFO_DEPTH(8), .DIV_WIDTH(16)) dut9 (
    .clk(clk), .nReset(nReset), .rate(rate), .parity_mode(pm), .two_stop(two),
    .cts(cts), .tx(tx9), .busy(busy9), .bus(bus9));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit par_on(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  function automatic int frame_bits(input int nb, input logic [1:0] m, input bit t);
    return 1 + nb + int'(par_on(m)) + (t ? 2 : 1);
  endfunction

  // Line level of bit slot k of a frame (0 = start bit)
  function automatic bit frame_bit(input int d, input int nb, input logic [1:0] m, input bit t, input int k);
    int ones;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += (d >> i) & 1;
    if (k == 0) return 1'b0;
    if (k <= nb) return bit'((d >> (k - 1)) & 1);
    if (k == nb + 1 && par_on(m)) return bit'(ones % 2) ^ (m == 2'b10);
    return 1'b1;
  endfunction

  // Model of the 8-bit instance: byte queue plus per-cycle line levels of the frame in flight
  int  mq[$];
  bit  mfr[$];
  bit  movr;
  int  mpre, md, mr;

  always @(posedge clk) begin
    if (!nReset) begin
      mq.delete(); mfr.delete(); movr = 1'b0;
    end else begin
      mpre = mq.size();
      if (mfr.size() != 0) void'(mfr.pop_front());
      if (mfr.size() == 0 && mpre != 0 && cts) begin
        md = mq.pop_front();
        mr = (rate < 2) ? 2 : int'(rate);
        for (int k = 0; k < frame_bits(8, pm, two); k++)
          for (int j = 0; j < mr; j++) mfr.push_back(frame_bit(md, 8, pm, two, k));
      end
      if (bus8.flush) begin
        mq.delete(); movr = 1'b0;
      end else if (bus8.push) begin
        if (mpre >= 8) movr = 1'b1;
        else mq.push_back(int'(bus8.push_data));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on && nReset)
      chk("cyc", {24'd0, tx8, busy8, bus8.full, bus8.level, bus8.overrun},
          {24'd0, (mfr.size() != 0) ? mfr[0] : 1'b1, mfr.size() != 0, mq.size() == 8,
           4'(mq.size()), movr});
  end

  task automatic push8(input logic [7:0] d);
    bus8.push = 1'b1; bus8.push_data = d;
    @(negedge clk);
    bus8.push = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int bound, input string tag);
    for (int i = 0; i < bound && busy8 !== lvl; i++) @(negedge clk);
    chk(tag, busy8, lvl);
  endtask

  task automatic run_frame(input int r, output int len, output logic [11:0] bits);
    bits = '1; len = 0;
    wait_busy(1'b1, 100, "to_start");
    while (busy8 && len < 2000) begin
      if (len % r == 0 && len / r < 12) bits[len / r] = tx8;
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int len, n;
    logic [11:0] bits;
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int len, n;
    logic [11:0] bits;
    nReset = 1'b0; rate = 16'd4; pm = 2'b00; two = 1'b0; cts = 1'b1;
    bus8.push = 1'b0; bus8.push_data = '0; bus8.flush = 1'b0;
    bus9.push = 1'b0; bus9.push_data = '0; bus9.flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx8, 1'b1);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_full", bus8.full, 1'b0);
    chk("rst_level", bus8.level, 4'd0);
    chk("rst_ovr", bus8.overrun, 1'b0);
    chk("rst_tx9", tx9, 1'b1);
    nReset = 1'b1; chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 at rate 4
    push8(8'hA5);
    chk("lvl1", bus8.level, 4'd1);
    @(negedge clk);
    chk("start_lat", tx8, 1'b0);
    run_frame(4, len, bits);
    chk("len_8n1", len, 40);
    chk("bits_8n1", bits[9:0], 10'b1101001010);

    // even parity, then odd parity with two stop bits
    pm = 2'b01;
    push8(8'hA5);
    run_frame(4, len, bits);
    chk("len_even", len, 44);
    chk("par_even", bits[9], 1'b0);
    pm = 2'b10; two = 1'b1;
    push8(8'hA5);
    run_frame(4, len, bits);
    chk("len_odd2", len, 48);
    chk("par_odd", bits[9], 1'b1);
    chk("stop2", bits[11:10], 2'b11);
    pm = 2'b00; two = 1'b0;

    // fill past capacity with cts low, then drain back-to-back
    cts = 1'b0;
    for (int i = 0; i < 9; i++) push8(8'(i * 17 + 3));
    chk("full", bus8.full, 1'b1);
    chk("lvl8", bus8.level, 4'd8);
    chk("ovr", bus8.overrun, 1'b1);
    cts = 1'b1;
    wait_busy(1'b1, 10, "drain_start");
    n = 0;
    while (busy8 && n < 1000) begin n++; @(negedge clk); end
    chk("drain_len", n, 320);

    // flush with a colliding push on a full FIFO
    cts = 1'b0;
    for (int i = 0; i < 9; i++) push8(8'(i));
    bus8.flush = 1'b1;
    push8(8'hEE);
    bus8.flush = 1'b0;
    chk("flush_lvl", bus8.level, 4'd0);
    chk("flush_ovr", bus8.overrun, 1'b0);

    // cts drop mid-frame
    push8(8'hA1); push8(8'hB2); push8(8'hC3);
    cts = 1'b1;
    wait_busy(1'b1, 10, "fc_start");
    repeat (20) @(negedge clk);
    cts = 1'b0;
    wait_busy(1'b0, 100, "fc_end1");
    repeat (30) @(negedge clk);
    chk("fc_hold_tx", tx8, 1'b1);
    chk("fc_hold_lvl", bus8.level, 4'd2);
    cts = 1'b1;
    @(negedge clk);
    chk("fc_resume", tx8, 1'b0);
    wait_busy(1'b0, 300, "fc_done");

    // reset during DATA
    push8(8'h5A); push8(8'h3C);
    repeat (10) @(negedge clk);
    chk_on = 1'b0;
    #2 nReset = 1'b0;
    #1;
    chk("mid_rst_tx", tx8, 1'b1);
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_lvl", bus8.level, 4'd0);
    @(negedge clk);
    nReset = 1'b1; chk_on = 1'b1;
    @(negedge clk);
    push8(8'hC3);
    run_frame(4, len, bits);
    chk("post_rst_len", len, 40);
    chk("post_rst_bits", bits[9:0], 10'b1110000110);

    // random traffic, config churn and cts toggling
    for (int c = 0; c < 3000; c++) begin
      bus8.push = ($urandom_range(0, 9) < 3);
      bus8.push_data = 8'($urandom);
      bus8.flush = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) cts = ~cts;
      if ($urandom_range(0, 49) == 0) begin
        rate = 16'($urandom_range(0, 5));
        pm = 2'($urandom);
        two = 1'($urandom);
      end
      @(negedge clk);
    end
    bus8.push = 1'b0; bus8.flush = 1'b0; cts = 1'b1;
    for (int i = 0; i < 6000 && (busy8 || bus8.level != 0); i++) @(negedge clk);
    chk("rand_drain", {busy8, bus8.level}, 5'd0);

    // 9-bit build with clamped rate
    rate = 16'd0; pm = 2'b00; two = 1'b0;
    bus9.push = 1'b1; bus9.push_data = 9'h1FF;
    @(negedge clk);
    bus9.push = 1'b0;
    chk("w9_lvl", bus9.level, 4'd1);
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      chk("w9", {tx9, busy9}, {(i >= 2) ? 1'b1 : 1'b0, (i < 22) ? 1'b1 : 1'b0});
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
